// File: rtl/flt2fix_unit.sv
// float16 -> signed fixed point (FRAC_BITS fraction bits), serial shifter, RNE rounding.
// Define FLT2FIX_FLAGS_EN to add the flags[2:0] = {invalid, overflow, inexact} output.
module flt2fix_unit #(
    parameter int FRAC_BITS  = 8,
    parameter int MAX_RSHIFT = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] flt_in,
    output logic [15:0] fix_out,
`ifdef FLT2FIX_FLAGS_EN
    output logic [2:0]  flags,
`endif
    output logic        busy,
    output logic        done
);

    localparam int         BIAS     = 25 - FRAC_BITS;
    localparam logic [5:0] E_LO     = 6'(BIAS);
    localparam logic [5:0] E_SAT    = 6'(BIAS + 5);
    localparam logic [5:0] RS_CLAMP = 6'(MAX_RSHIFT);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] op;
    logic [15:0] mag;
    logic        guard;
    logic        sticky;
    logic        go_left_q;
    logic [4:0]  cnt;

    logic        op_s;
    logic [4:0]  op_e;
    logic [9:0]  op_m;
    logic [5:0]  op_e6;

    assign op_s  = op[15];
    assign op_e  = op[14:10];
    assign op_m  = op[9:0];
    assign op_e6 = {1'b0, op_e};

    // Operand classification: specials resolve directly in UNPACK.
    logic        sp_hit;
    logic [15:0] sp_res;
`ifdef FLT2FIX_FLAGS_EN
    logic [2:0]  sp_flg;
`endif

    always_comb begin
        sp_hit = 1'b0;
        sp_res = 16'h0000;
`ifdef FLT2FIX_FLAGS_EN
        sp_flg = 3'b000;
`endif
        if (op_e == 5'd31) begin
            sp_hit = 1'b1;
            if (op_m != 10'd0) begin
                sp_res = 16'h7FFF;
`ifdef FLT2FIX_FLAGS_EN
                sp_flg = 3'b100;
`endif
            end else begin
                sp_res = op_s ? 16'h8000 : 16'h7FFF;
`ifdef FLT2FIX_FLAGS_EN
                sp_flg = 3'b010;
`endif
            end
        end else if (op_e == 5'd0) begin
            sp_hit = 1'b1;
            sp_res = 16'h0000;
`ifdef FLT2FIX_FLAGS_EN
            sp_flg = {2'b00, |op_m};
`endif
        end else if (op_e6 >= E_SAT) begin
            sp_hit = 1'b1;
            if (op_s && (op_e6 == E_SAT) && (op_m == 10'd0)) begin
                sp_res = 16'h8000;
            end else begin
                sp_res = op_s ? 16'h8000 : 16'h7FFF;
`ifdef FLT2FIX_FLAGS_EN
                sp_flg = 3'b010;
`endif
            end
        end
    end

    // Shift direction and step count for the normal path.
    logic       go_left;
    logic [5:0] kdiff;
    logic [4:0] k_cnt;

    always_comb begin
        go_left = (op_e6 >= E_LO);
        kdiff   = go_left ? (op_e6 - E_LO) : (E_LO - op_e6);
        if (!go_left && (kdiff > RS_CLAMP)) begin
            k_cnt = RS_CLAMP[4:0];
        end else begin
            k_cnt = kdiff[4:0];
        end
    end

    // Round to nearest, ties to even, then apply sign.
    logic        rnd_up;
    logic [15:0] rnd_mag;
    logic [15:0] rnd_res;

    always_comb begin
        rnd_up  = guard & (sticky | mag[0]);
        rnd_mag = mag + {15'd0, rnd_up};
        rnd_res = op_s ? (-rnd_mag) : rnd_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= 16'h0000;
            mag       <= 16'h0000;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            go_left_q <= 1'b0;
            cnt       <= 5'd0;
            fix_out   <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef FLT2FIX_FLAGS_EN
            flags     <= 3'b000;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= flt_in;
                        busy  <= 1'b1;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    mag       <= {5'd0, 1'b1, op_m};
                    guard     <= 1'b0;
                    sticky    <= 1'b0;
                    go_left_q <= go_left;
                    cnt       <= k_cnt;
                    if (sp_hit) begin
                        fix_out <= sp_res;
`ifdef FLT2FIX_FLAGS_EN
                        flags   <= sp_flg;
`endif
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (k_cnt == 5'd0) begin
                        state <= ROUND;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (go_left_q) begin
                        mag <= {mag[14:0], 1'b0};
                    end else begin
                        mag    <= {1'b0, mag[15:1]};
                        guard  <= mag[0];
                        sticky <= sticky | guard;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    fix_out <= rnd_res;
`ifdef FLT2FIX_FLAGS_EN
                    flags   <= {2'b00, guard | sticky};
`endif
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flt2fix_unit.sv
// Scoreboard bench for flt2fix_unit: real-valued reference model, directed,
// random, handshake and fix->float->fix round-trip stimulus.
`timescale 1ns/1ps
module tb_flt2fix_unit;

    localparam int FRAC = 8;
    localparam int B    = 25 - FRAC;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] flt_in;
    logic [15:0] fix_out;
    logic        busy;
    logic        done;
`ifdef FLT2FIX_FLAGS_EN
    logic [2:0]  flags;
`endif

    flt2fix_unit #(
        .FRAC_BITS (FRAC),
        .MAX_RSHIFT(13)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flt_in (flt_in),
        .fix_out(fix_out),
`ifdef FLT2FIX_FLAGS_EN
        .flags  (flags),
`endif
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic real pow2(input int n);
        real p;
        p = 1.0;
        if (n >= 0) repeat (n) p = p * 2.0;
        else repeat (-n) p = p / 2.0;
        return p;
    endfunction

    // Reference: decode to a real, scale, round half-even, saturate.
    function automatic void ref_conv(input logic [15:0] f,
                                     output logic [15:0] res,
                                     output logic [2:0] flg,
                                     output int lat);
        int  e, m, k, r;
        bit  s;
        real x, fl, fr;
        s   = f[15];
        e   = int'(f[14:10]);
        m   = int'(f[9:0]);
        flg = 3'b000;
        lat = 2;
        if (e == 31) begin
            res = (m != 0 || !s) ? 16'h7FFF : 16'h8000;
            flg = (m != 0) ? 3'b100 : 3'b010;
            return;
        end
        if (e == 0) begin
            res = 16'h0000;
            flg = {2'b00, m != 0};
            return;
        end
        x  = real'(1024 + m) * pow2(e - B);
        fl = $floor(x);
        fr = x - fl;
        r  = $rtoi(fl);
        if (fr > 0.5 || (fr == 0.5 && (r % 2) != 0)) r++;
        if (s) r = -r;
        if (r > 32767) begin
            res = 16'h7FFF;
            flg = 3'b010;
        end else if (r < -32768) begin
            res = 16'h8000;
            flg = 3'b010;
        end else begin
            res = 16'(r);
            flg = {2'b00, fr != 0.0};
        end
        if (e >= B + 5) begin
            lat = 2;
        end else begin
            k   = (e >= B) ? (e - B) : ((B - e > 13) ? 13 : (B - e));
            lat = k + 3;
        end
    endfunction

    // Upstream fixed-to-float stage model (8.8 -> float16, RNE to 11 bits).
    function automatic logic [15:0] fix2flt(input logic [15:0] v);
        logic s;
        int   a, p, sig, sh, rem, half;
        if (v == 16'h0000) return 16'h0000;
        s = v[15];
        a = s ? (65536 - int'(v)) : int'(v);
        p = 0;
        for (int i = 0; i < 16; i++) if (((a >> i) & 1) != 0) p = i;
        if (p <= 10) begin
            sig = a << (10 - p);
        end else begin
            sh   = p - 10;
            sig  = a >> sh;
            rem  = a - (sig << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
            if (sig == 2048) begin
                sig = 1024;
                p++;
            end
        end
        return {s, 5'(p + 7), 10'(sig)};
    endfunction

    function automatic logic [15:0] round11(input logic [15:0] v);
        logic s;
        int   a, sc, q, r;
        s  = v[15];
        a  = s ? (65536 - int'(v)) : int'(v);
        if (v == 16'h0000) a = 0;
        sc = 1;
        while (a / sc >= 2048) sc = sc * 2;
        q = a / sc;
        r = a % sc;
        if (sc > 1 && (2 * r > sc || (2 * r == sc && (q % 2) == 1))) q++;
        a = q * sc;
        if (s) a = -a;
        if (a > 32767) a = 32767;
        return 16'(a);
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                check("done expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("fix_out", fix_out, e.res);
                    check("latency", cyc - e.acc + 1, e.lat);
`ifdef FLT2FIX_FLAGS_EN
                    check("flags", flags, e.flg);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [15:0] res, input logic [2:0] flg,
                            input int lat);
        exp_t e;
        e.res = res;
        e.flg = flg;
        e.lat = lat;
        e.acc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_dones(input int target);
        int w;
        w = 0;
        while (n_done < target && w < 60) begin
            @(posedge clk);
            #2;
            w++;
        end
        check("done count", n_done, target);
    endtask

    task automatic conv(input logic [15:0] f, input logic [15:0] res,
                        input logic [2:0] flg, input int lat);
        int seen;
        seen = n_done;
        push_exp(res, flg, lat);
        flt_in = f;
        start  = 1'b1;
        @(posedge clk);
        #2;
        start  = 1'b0;
        flt_in = 16'($urandom);
        check("busy after accept", busy, 1);
        wait_dones(seen + 1);
        @(posedge clk);
        #2;
    endtask

    task automatic conv_m(input logic [15:0] f);
        logic [15:0] r;
        logic [2:0]  fl;
        int          l;
        ref_conv(f, r, fl, l);
        conv(f, r, fl, l);
    endtask

    initial begin
        logic [15:0] hv [5];
        logic [15:0] r;
        logic [2:0]  fl;
        logic [15:0] v;
        logic [15:0] fv;
        int          l;
        int          seen;

        reset  = 1'b1;
        start  = 1'b0;
        flt_in = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        check("reset fix_out", fix_out, 16'h0000);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
`ifdef FLT2FIX_FLAGS_EN
        check("reset flags", flags, 3'b000);
`endif
        reset = 1'b0;
        @(posedge clk);
        #2;

        conv(16'h3C00, 16'h0100, 3'b000, 5);
        conv(16'h3E00, 16'h0180, 3'b000, 5);
        conv(16'hBC00, 16'hFF00, 3'b000, 5);
        conv(16'h4400, 16'h0400, 3'b000, 3);
        conv(16'h4C00, 16'h1000, 3'b000, 5);
        conv(16'h3555, 16'h0055, 3'b001, 7);
        conv(16'h1800, 16'h0000, 3'b001, 14);
        conv(16'h1A00, 16'h0001, 3'b001, 14);
        conv(16'h1C00, 16'h0001, 3'b000, 13);
        conv(16'h5800, 16'h7FFF, 3'b010, 2);
        conv(16'hD800, 16'h8000, 3'b000, 2);
        conv(16'h57FF, 16'h7FF0, 3'b000, 7);
        conv(16'h7E00, 16'h7FFF, 3'b100, 2);
        conv(16'h7C00, 16'h7FFF, 3'b010, 2);
        conv(16'hFC00, 16'h8000, 3'b010, 2);
        conv(16'h8000, 16'h0000, 3'b000, 2);
        conv(16'h0001, 16'h0000, 3'b001, 2);

        // start pulsed while busy must be ignored
        conv(16'h3C00, 16'h0100, 3'b000, 5);
        seen = n_done;
        push_exp(16'h1000, 3'b000, 5);
        flt_in = 16'h4C00;
        start  = 1'b1;
        @(posedge clk);
        #2;
        start  = 1'b0;
        flt_in = 16'h7E00;
        @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("fix_out held while busy", fix_out, 16'h0100);
        wait_dones(seen + 1);
        repeat (12) @(posedge clk);
        #2;
        check("no extra done", n_done, seen + 1);

        // reset during SHIFT aborts with no done
        seen   = n_done;
        flt_in = 16'h0400;
        start  = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("abort busy", busy, 0);
        check("abort fix_out", fix_out, 16'h0000);
        check("abort done", done, 0);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check("no done after abort", n_done, seen);

        // start held high: back-to-back conversions
        hv[0] = 16'h3C00;
        hv[1] = 16'h7E00;
        hv[2] = 16'h57FF;
        hv[3] = 16'h1C00;
        hv[4] = 16'hD800;
        seen  = n_done;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ref_conv(hv[i], r, fl, l);
            push_exp(r, fl, l);
            flt_in = hv[i];
            @(posedge clk);
            #2;
            if (i == 4) begin
                start = 1'b0;
            end else begin
                repeat (l) @(posedge clk);
                #2;
            end
        end
        wait_dones(seen + 5);
        repeat (4) @(posedge clk);
        #2;
        check("held start done total", n_done, seen + 5);

        for (int i = 0; i < 250; i++) begin
            conv_m(16'($urandom));
        end

        for (int i = 0; i < 100; i++) begin
            v  = 16'($urandom);
            fv = fix2flt(v);
            ref_conv(fv, r, fl, l);
            conv(fv, round11(v), fl, l);
        end

        repeat (5) @(posedge clk);
        #2;
        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
